// File: rtl/nexys4_ddr_top.sv
// Nexys4-DDR wrapper: reset generator, UART debug master (udm) and a CSR/test-memory bus slave.
// Optional macro NEXYS4_TESTMEM_EN maps a 64x32 test memory at 0x8000_0000.

module udm #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srst,
  input  logic        rx,
  output logic        tx,
  output logic        req,
  output logic        we,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic        resp,
  input  logic [31:0] rdata
);
  // Frame protocol: cmd (0x01 write / 0x02 read), addr[31:0] MSB first,
  // writes add be byte and wdata MSB first. Reply: status {7'b0,resp}, reads add rdata MSB first.
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_BE, S_DATA, S_BUS, S_RESP, S_RDATA} state_t;
  state_t st, nxt;

  logic [1:0]  rx_m;
  logic        rx_busy, rx_vld;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh;

  logic        tx_busy, tx_go;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_sh;
  logic [7:0]  tx_byte;

  logic        we_q, resp_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 2'b11; rx_busy <= 1'b0; rx_vld <= 1'b0;
      rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else if (srst) begin
      rx_m <= 2'b11; rx_busy <= 1'b0; rx_vld <= 1'b0;
      rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_m   <= {rx_m[0], rx};
      rx_vld <= 1'b0;
      if (!rx_busy) begin
        if (!rx_m[1]) begin
          rx_busy <= 1'b1; rx_cnt <= HALF; rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= FULL;
        if (rx_bit == 4'd0) begin
          // a start bit that is high again at mid-bit was a glitch
          if (rx_m[1]) rx_busy <= 1'b0;
          else         rx_bit  <= 4'd1;
        end else if (rx_bit < 4'd9) begin
          rx_sh  <= {rx_m[1], rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end else begin
          rx_busy <= 1'b0;
          rx_vld  <= rx_m[1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (srst) begin
      tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (tx_go) begin
      tx_sh <= {1'b1, tx_byte, 1'b0}; tx_busy <= 1'b1; tx_cnt <= FULL; tx_bit <= '0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - 16'd1;
      else begin
        tx_cnt <= FULL;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else                tx_bit  <= tx_bit + 4'd1;
      end
    end
  end

  assign tx = tx_sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    st <= S_CMD;
    else if (srst) st <= S_CMD;
    else           st <= nxt;
  end

  always_comb begin
    nxt = st; req = 1'b0; tx_go = 1'b0; tx_byte = 8'h00;
    case (st)
      S_CMD:   if (rx_vld && (rx_sh == 8'h01 || rx_sh == 8'h02)) nxt = S_ADDR;
      S_ADDR:  if (rx_vld && byte_cnt == 2'd3) nxt = we_q ? S_BE : S_BUS;
      S_BE:    if (rx_vld) nxt = S_DATA;
      S_DATA:  if (rx_vld && byte_cnt == 2'd3) nxt = S_BUS;
      S_BUS: begin
        req = 1'b1;
        if (ack) nxt = S_RESP;
      end
      S_RESP: if (!tx_busy) begin
        tx_go = 1'b1; tx_byte = {7'b0, resp_q};
        nxt = we_q ? S_CMD : S_RDATA;
      end
      S_RDATA: if (!tx_busy) begin
        tx_go = 1'b1; tx_byte = rdata_q[31:24];
        if (byte_cnt == 2'd3) nxt = S_CMD;
      end
      default: nxt = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0; resp_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
      rdata_q <= '0; be_q <= '0; byte_cnt <= '0;
    end else if (srst) begin
      we_q <= 1'b0; resp_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
      rdata_q <= '0; be_q <= '0; byte_cnt <= '0;
    end else begin
      case (st)
        S_CMD: begin
          byte_cnt <= '0;
          be_q     <= 4'hF;
          if (rx_vld) we_q <= (rx_sh == 8'h01);
        end
        S_ADDR: if (rx_vld) begin
          addr_q <= {addr_q[23:0], rx_sh}; byte_cnt <= byte_cnt + 2'd1;
        end
        S_BE:   if (rx_vld) be_q <= rx_sh[3:0];
        S_DATA: if (rx_vld) begin
          wdata_q <= {wdata_q[23:0], rx_sh}; byte_cnt <= byte_cnt + 2'd1;
        end
        S_BUS: if (ack) begin
          resp_q <= resp; rdata_q <= rdata; byte_cnt <= '0;
        end
        S_RDATA: if (!tx_busy) begin
          rdata_q <= {rdata_q[23:0], 8'h00}; byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign we    = we_q;
  assign addr  = addr_q;
  assign be    = be_q;
  assign wdata = wdata_q;
endmodule

module nexys4_ddr_top #(
  parameter     SIM      = "NO",
  parameter int BAUD_DIV = 868
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  input  logic        UART_TXD_IN,
  output logic        UART_RXD_OUT
);
  localparam int STRETCH = (SIM == "YES") ? 16 : 1024;

  logic [1:0]  rst_sync;
  logic [10:0] rst_cnt;
  logic        srst;

  // srst asserts asynchronously, releases after sync + stretch
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_sync <= '0; rst_cnt <= '0; srst <= 1'b1;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      if (rst_sync[1] && srst) begin
        if (rst_cnt == 11'(STRETCH - 1)) srst    <= 1'b0;
        else                             rst_cnt <= rst_cnt + 11'd1;
      end
    end
  end

  logic [15:0] sw_m, sw_s;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)  begin sw_m <= '0; sw_s <= '0; end
    else if (srst)    begin sw_m <= '0; sw_s <= '0; end
    else              begin sw_m <= SW; sw_s <= sw_m; end
  end

  logic        req, we, ack, resp;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  udm #(.CLKS_PER_BIT(BAUD_DIV)) udm (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .srst(srst),
    .rx(UART_TXD_IN), .tx(UART_RXD_OUT),
    .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .ack(ack), .resp(resp), .rdata(rdata)
  );

  logic [31:0] led_csr, scratch, csr_rd, rd_csr;
  logic        sel_led, sel_sw, sel_scr, sel_mem, mem_hit, acc, wr;
  logic        unused_addr;
  assign unused_addr = ^addr[1:0];

  // acc: first cycle of a request; wr: commit writes in the ack cycle
  assign acc = req & ~ack;
  assign wr  = req & ack & we;

  always_comb begin
    sel_led = (addr[31:2] == 30'd0);
    sel_sw  = (addr[31:2] == 30'd1);
    sel_scr = (addr[31:2] == 30'd2);
`ifdef NEXYS4_TESTMEM_EN
    sel_mem = (addr[31:8] == 24'h80_0000);
`else
    sel_mem = 1'b0;
`endif
    csr_rd = '0;
    if (sel_led) csr_rd = led_csr;
    if (sel_sw)  csr_rd = {16'h0, sw_s};
    if (sel_scr) csr_rd = scratch;
  end

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ack <= 1'b0; resp <= 1'b0; rd_csr <= '0; mem_hit <= 1'b0;
      led_csr <= '0; scratch <= '0;
    end else if (srst) begin
      ack <= 1'b0; resp <= 1'b0; rd_csr <= '0; mem_hit <= 1'b0;
      led_csr <= '0; scratch <= '0;
    end else begin
      ack <= acc;
      if (acc) begin
        resp    <= ~(sel_led | sel_sw | sel_scr | sel_mem);
        rd_csr  <= csr_rd;
        mem_hit <= sel_mem;
      end
      if (wr && sel_led) led_csr <= bmerge(led_csr, wdata, be);
      if (wr && sel_scr) scratch <= bmerge(scratch, wdata, be);
    end
  end

`ifdef NEXYS4_TESTMEM_EN
  logic [31:0] mem [64];
  logic [31:0] mem_q;

  // contents survive reset; only the write strobe is gated by srst
  always_ff @(posedge CLK100MHZ) begin
    if (wr && sel_mem && !srst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr[7:2]][8*i +: 8] <= wdata[8*i +: 8];
    mem_q <= mem[addr[7:2]];
  end

  assign rdata = mem_hit ? mem_q : rd_csr;
`else
  assign rdata = mem_hit ? 32'h0 : rd_csr;
`endif

  assign LED = led_csr[15:0];
endmodule

// File: tb/tb_nexys4_ddr_top.sv
// Directed bench for nexys4_ddr_top: drives UDM frames over the UART pins and checks replies.
module tb_nexys4_ddr_top;
  localparam int D = 16;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN;
  logic [15:0] SW;
  logic [15:0] LED;
  logic        UART_TXD_IN;
  logic        UART_RXD_OUT;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  x_status;
  logic [31:0] x_rdata;
  bit          x_ok;

  nexys4_ddr_top #(.SIM("YES"), .BAUD_DIV(D)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .SW(SW), .LED(LED),
    .UART_TXD_IN(UART_TXD_IN), .UART_RXD_OUT(UART_RXD_OUT)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_TXD_IN = f[i];
      repeat (D) @(negedge CLK100MHZ);
    end
  endtask

  task automatic recv_byte(output logic [7:0] v);
    int n;
    n = 0; v = 8'h00;
    if (!x_ok) return;
    while (UART_RXD_OUT !== 1'b0 && n < 4000) begin
      @(negedge CLK100MHZ); n++;
    end
    if (n >= 4000) begin x_ok = 0; return; end
    repeat (D/2) @(negedge CLK100MHZ);
    for (int i = 0; i < 8; i++) begin
      repeat (D) @(negedge CLK100MHZ);
      v[i] = UART_RXD_OUT;
    end
    repeat (D) @(negedge CLK100MHZ);
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    x_ok = 1; x_status = 8'hxx; x_rdata = 32'h0;
    fork
      begin
        send_byte(w ? 8'h01 : 8'h02);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (w) begin
          send_byte({4'h0, b});
          for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        end
      end
      begin
        logic [7:0] rb;
        recv_byte(x_status);
        if (!w) for (int i = 0; i < 4; i++) begin
          recv_byte(rb);
          x_rdata = {x_rdata[23:0], rb};
        end
      end
    join
    n_total++;
    if (!x_ok) $display("FAIL uart_reply addr=%h: no reply from udm within timeout", a);
    else n_pass++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                    input logic [7:0] exp_st);
    xact(1'b1, a, b, d);
    n_total++;
    if (x_status !== exp_st) $display("FAIL wr_status addr=%h got %h exp %h", a, x_status, exp_st);
    else n_pass++;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp_st, input logic [31:0] exp_d);
    xact(1'b0, a, 4'hF, 32'h0);
    n_total++;
    if (x_status !== exp_st || x_rdata !== exp_d)
      $display("FAIL rd addr=%h got st=%h data=%h exp st=%h data=%h", a, x_status, x_rdata, exp_st, exp_d);
    else n_pass++;
  endtask

  task automatic wait_srst_release(input string tag);
    int n;
    n = 0;
    while (dut.srst !== 1'b0 && n < 100) begin @(negedge CLK100MHZ); n++; end
    n_total++;
    if (n < 16 || n > 24) $display("FAIL %s srst release after %0d cycles exp 16..24", tag, n);
    else n_pass++;
  endtask

  task automatic test_reset;
    CPU_RESETN = 1'b0; SW = 16'h0; UART_TXD_IN = 1'b1;
    #30;
    n_total++;
    if (dut.srst !== 1'b1 || LED !== 16'h0 || UART_RXD_OUT !== 1'b1)
      $display("FAIL reset_hold srst=%b led=%h txd=%b exp 1 0000 1", dut.srst, LED, UART_RXD_OUT);
    else n_pass++;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    wait_srst_release("reset");
    n_total++;
    if (LED !== 16'h0 || UART_RXD_OUT !== 1'b1)
      $display("FAIL reset_after led=%h txd=%b exp 0000 1", LED, UART_RXD_OUT);
    else n_pass++;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic test_led;
    wr(32'h0000_0000, 4'hF, 32'h5A5A_5A5A, 8'h00);
    n_total++;
    if (LED !== 16'h5A5A) $display("FAIL led_full got %h exp 5a5a", LED); else n_pass++;
    rd(32'h0000_0000, 8'h00, 32'h5A5A_5A5A);
    wr(32'h0000_0000, 4'b0001, 32'h0000_00FF, 8'h00);
    n_total++;
    if (LED !== 16'h5AFF) $display("FAIL led_be got %h exp 5aff", LED); else n_pass++;
    rd(32'h0000_0002, 8'h00, 32'h5A5A_5AFF);
  endtask

  task automatic test_sw;
    SW = 16'h0030;
    repeat (4) @(negedge CLK100MHZ);
    rd(32'h0000_0004, 8'h00, 32'h0000_0030);
    SW = 16'h0031;
    repeat (4) @(negedge CLK100MHZ);
    rd(32'h0000_0004, 8'h00, 32'h0000_0031);
    wr(32'h0000_0004, 4'hF, 32'hFFFF_FFFF, 8'h00);
    rd(32'h0000_0004, 8'h00, 32'h0000_0031);
  endtask

  task automatic test_scratch;
    wr(32'h0000_0008, 4'hF, 32'h0001_7ED0, 8'h00);
    rd(32'h0000_0008, 8'h00, 32'h0001_7ED0);
    n_total++;
    if (LED !== 16'h5AFF) $display("FAIL scratch_led got %h exp 5aff", LED); else n_pass++;
    wr(32'h0000_0008, 4'b1010, 32'hAABB_CCDD, 8'h00);
    rd(32'h0000_0008, 8'h00, 32'hAA01_CCD0);
  endtask

  task automatic test_unmapped;
    rd(32'h4000_0000, 8'h01, 32'h0);
    wr(32'h4000_0000, 4'hF, 32'hFFFF_FFFF, 8'h01);
    rd(32'h0000_000C, 8'h01, 32'h0);
    n_total++;
    if (LED !== 16'h5AFF) $display("FAIL unmapped_led got %h exp 5aff", LED); else n_pass++;
  endtask

  task automatic test_mem;
`ifdef NEXYS4_TESTMEM_EN
    wr(32'h8000_0000, 4'hF, 32'h1122_33CC, 8'h00);
    wr(32'h8000_003C, 4'hF, 32'hBADC_0FFE, 8'h00);
    rd(32'h8000_0000, 8'h00, 32'h1122_33CC);
    rd(32'h8000_003C, 8'h00, 32'hBADC_0FFE);
    wr(32'h8000_0024, 4'hF, 32'hDEAD_BEEF, 8'h00);
    rd(32'h8000_0024, 8'h00, 32'hDEAD_BEEF);
    wr(32'h8000_0024, 4'b0100, 32'h0077_0000, 8'h00);
    rd(32'h8000_0024, 8'h00, 32'hDE77_BEEF);
`else
    rd(32'h8000_0000, 8'h01, 32'h0);
    wr(32'h8000_0000, 4'hF, 32'h1234_5678, 8'h01);
    rd(32'h8000_00FC, 8'h01, 32'h0);
    n_total++;
    if (LED !== 16'h5AFF) $display("FAIL memoff_led got %h exp 5aff", LED); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b0;
    #2;
    n_total++;
    if (dut.srst !== 1'b1 || LED !== 16'h0)
      $display("FAIL midreset_async srst=%b led=%h exp 1 0000", dut.srst, LED);
    else n_pass++;
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    wait_srst_release("midreset");
    repeat (4) @(negedge CLK100MHZ);
    rd(32'h0000_0000, 8'h00, 32'h0);
    rd(32'h0000_0008, 8'h00, 32'h0);
`ifdef NEXYS4_TESTMEM_EN
    rd(32'h8000_003C, 8'h00, 32'hBADC_0FFE);
`endif
  endtask

  initial begin
    test_reset;
    test_led;
    test_sw;
    test_scratch;
    test_unmapped;
    test_mem;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
